mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the microprogrammed control unit. It holds the MAR and MBR, executes read and write requests against an internal 256×8 RAM after a fixed access latency, and signals completion with a one-cycle MFC pulse. The control unit stalls on this pulse while its WMFC microstep is active. The block sits between the internal processor bus and memory, on the far side of the MAR_in, MBR_out, rnw and WMFC control lines.

## Interface
Parameters:
- LAT, default 2: access latency in cycles from request acceptance to the MFC pulse. Legal range is 1..15.
- DEPTH, default 256: RAM words. The address is 8 bits wide.

Ports:
- CLK  in  1  system clock. All state changes on its rising edge.
- RST  in  1  synchronous, active-high reset.
- bus_in  in  8  internal processor bus value.
- MAR_in  in  1  load MAR from bus_in.
- MBR_in  in  1  load MBR from bus_in.
- MBR_out  in  1  drive MBR onto bus_out.
- bus_out  out  8  equals MBR when MBR_out=1, otherwise 8'h00.
- req  in  1  single-cycle start strobe, issued on the first cycle of the WMFC microstep.
- rnw  in  1  sampled with req: 1 = read, 0 = write.
- MFC  out  1  memory-function-complete pulse.
- busy  out  1  high while a transaction is pending.
- prog_we  in  1  back-door RAM write, used for program loading.
- prog_addr  in  8  back-door address.
- prog_data  in  8  back-door data.

## Operation
- State machine with three states: IDLE, BUSY, DONE. Reset enters IDLE.
- In IDLE:
  - MAR_in=1 loads MAR. MBR_in=1 loads MBR.
  - req=1 latches addr_q=MAR, dir_q=rnw, wdata_q=MBR, sets cnt=LAT-1 and goes to BUSY.
  - If MAR_in or MBR_in are asserted in the same cycle as req, the latched values are the pre-edge MAR/MBR. The load still updates the register.
- In BUSY:
  - cnt decrements each cycle.
  - When cnt==0, go to DONE on the next edge:
    - read: MBR ← RAM[addr_q].
    - write: RAM[addr_q] ← wdata_q.
  - MAR_in, MBR_in and req are ignored. No error flag is raised.
- In DONE: MFC=1 for exactly this one cycle, then go to IDLE. req in DONE is ignored.
- req must be a pulse. A req held high is re-accepted in the next IDLE cycle and starts a second transaction.
- prog_we is honoured only in IDLE with req=0. It writes RAM[prog_addr] ← prog_data. Otherwise it is dropped.
- Reset:
  - Outputs and registers: MAR=0, MBR=0, cnt=0, MFC=0, busy=0, bus_out=0.
  - RAM contents are not cleared.
  - Reset during BUSY aborts the transaction: no RAM write, no MBR update, no MFC.
- Address wraps naturally at 8 bits; no bounds check is performed.

## Timing
- busy=1 in BUSY and DONE, and 0 in IDLE.
- With req accepted at edge T:
  - BUSY occupies cycles T..T+LAT-1.
  - DONE, MFC=1 and the read data in MBR are all visible after edge T+LAT.
  - The block is back in IDLE after edge T+LAT+1.
- Minimum spacing between accepted requests is LAT+2 edges.
- bus_out is combinational from MBR and MBR_out, with zero latency.
- A write is visible to a read whose req is accepted at or after edge T+LAT+1.

## Test plan
- Reset: drive RST for 2 cycles with arbitrary inputs. Required: MAR=0, MBR=0, MFC=0, busy=0, bus_out=0.
- Read, LAT=2: prog-load RAM[8'h10]=8'hA5, MAR_in with bus_in=8'h10, then req with rnw=1 at edge T. Required:
  - MFC high only after edge T+2.
  - MBR=8'hA5 in that cycle.
  - bus_out=8'hA5 when MBR_out=1.
  - busy low after edge T+3.
- Write then read-back: MAR=8'hFF, MBR=8'h3C, req with rnw=0. Then after MFC, load MBR=8'h00 and req with rnw=1. Required: second MFC with MBR=8'h3C, confirming the write to address 8'hFF without wrap faults.
- Ignored inputs while BUSY: MAR_in with 8'h55, MBR_in with 8'h77, req and prog_we all asserted mid-transaction. Required:
  - The transaction completes on the original addr_q.
  - No second MFC.
  - prog write absent from RAM.
  - MBR reflects the read result.
- Reset mid-write: write req to 8'h20 (old value 8'h11), RST asserted in BUSY. Required:
  - RAM[8'h20] stays 8'h11.
  - MFC never rises.
  - FSM is in IDLE.
- Held req, LAT=1: req held high for 4 cycles. Required: two transactions, with MFC pulses exactly 3 edges apart.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder holding MAR/MBR and a DEPTH x 8 RAM.
// A req in IDLE snapshots MAR/MBR/rnw, waits LAT cycles in BUSY, performs the
// access, then pulses MFC for one cycle in DONE before returning to IDLE.
module mem_responder #(
    parameter int LAT   = 2,
    parameter int DEPTH = 256
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] bus_in,
    input  logic       MAR_in,
    input  logic       MBR_in,
    input  logic       MBR_out,
    output logic [7:0] bus_out,
    input  logic       req,
    input  logic       rnw,
    output logic       MFC,
    output logic       busy,
    input  logic       prog_we,
    input  logic [7:0] prog_addr,
    input  logic [7:0] prog_data
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] mar;
    logic [7:0] mbr;
    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic       dir_q;
    logic [3:0] cnt;
    logic       accept;
    logic       finish;
    logic [7:0] ram [DEPTH];

    // State register; reset always lands in IDLE, aborting any transaction.
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode plus the MFC/busy status derived from the state.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        MFC       = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (req) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                MFC       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // MAR/MBR loads (IDLE only), latency counter and read-data capture.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mar <= 8'h00;
            mbr <= 8'h00;
            cnt <= 4'd0;
        end else begin
            if (state == IDLE) begin
                if (MAR_in) mar <= bus_in;
                if (MBR_in) mbr <= bus_in;
            end
            if (accept)
                cnt <= CNT_INIT;
            else if (state == BUSY && cnt != 4'd0)
                cnt <= cnt - 4'd1;
            if (finish && dir_q)
                mbr <= ram[addr_q];
        end
    end

    // Transaction snapshot; takes the pre-edge MAR/MBR even if they load now.
    always_ff @(posedge CLK) begin
        if (accept) begin
            addr_q  <= mar;
            dir_q   <= rnw;
            wdata_q <= mbr;
        end
    end

    // RAM write port: transaction writes, else back-door loads in quiet IDLE.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (finish && !dir_q)
                ram[addr_q] <= wdata_q;
            else if (state == IDLE && !req && prog_we)
                ram[prog_addr] <= prog_data;
        end
    end

    assign bus_out = MBR_out ? mbr : 8'h00;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder with a RAM/register model.
module tb_mem_responder;

    localparam int LAT_M = 2;

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] bus_in;
    logic       MAR_in, MBR_in, MBR_out, req, rnw, req1;
    logic       prog_we;
    logic [7:0] prog_addr, prog_data;
    logic [7:0] bus_out, bus_out1;
    logic       MFC, busy, MFC1, busy1;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    exp_t       sbq[$];
    exp_t       mon_e;
    int         mfc1_q[$];
    logic [7:0] mram [256];
    logic [7:0] mmar, mmbr;

    mem_responder #(.LAT(LAT_M), .DEPTH(256)) u_dut (
        .CLK(CLK), .RST(RST), .bus_in(bus_in), .MAR_in(MAR_in), .MBR_in(MBR_in),
        .MBR_out(MBR_out), .bus_out(bus_out), .req(req), .rnw(rnw), .MFC(MFC),
        .busy(busy), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );

    mem_responder #(.LAT(1), .DEPTH(256)) u_dut1 (
        .CLK(CLK), .RST(RST), .bus_in(bus_in), .MAR_in(MAR_in), .MBR_in(MBR_in),
        .MBR_out(MBR_out), .bus_out(bus_out1), .req(req1), .rnw(rnw), .MFC(MFC1),
        .busy(busy1), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) edge_n++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Monitor: every MFC pulse must match the oldest expected completion.
    always @(negedge CLK) begin
        if (sbq.size() > 0 && edge_n > sbq[0].cyc) begin
            chk("mfc_missing", 32'd0, 32'd1);
            void'(sbq.pop_front());
        end
        if (MFC === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("mfc_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("mfc_cycle", edge_n, mon_e.cyc);
                chk("mfc_mbr", {24'd0, bus_out}, MBR_out ? {24'd0, mon_e.data} : 32'd0);
                chk("busy_at_mfc", {31'd0, busy}, 32'd1);
            end
        end
    end

    // Records MFC pulses of the LAT=1 instance.
    always @(negedge CLK) begin
        if (MFC1 === 1'b1) mfc1_q.push_back(edge_n);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic prog(input logic [7:0] a, input logic [7:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick();
        prog_we = 1'b0;
        mram[a] = d;
    endtask

    task automatic load_mar(input logic [7:0] v);
        MAR_in = 1'b1; bus_in = v;
        tick();
        MAR_in = 1'b0;
        mmar = v;
    endtask

    task automatic load_mbr(input logic [7:0] v);
        MBR_in = 1'b1; bus_in = v;
        tick();
        MBR_in = 1'b0;
        mmbr = v;
    endtask

    // One transaction; optional same-cycle MAR/MBR loads with bus value bv.
    task automatic txn(input logic rd, input logic ld_mar, input logic ld_mbr, input logic [7:0] bv);
        exp_t e;
        logic [7:0] d;
        req = 1'b1; rnw = rd; MBR_out = 1'b1;
        MAR_in = ld_mar; MBR_in = ld_mbr; bus_in = bv;
        if (rd) d = mram[mmar];
        else    mram[mmar] = mmbr;
        if (ld_mar) mmar = bv;
        if (ld_mbr) mmbr = bv;
        if (rd) mmbr = d;
        e.cyc  = edge_n + 1 + LAT_M;
        e.data = mmbr;
        sbq.push_back(e);
        tick();
        req = 1'b0; MAR_in = 1'b0; MBR_in = 1'b0;
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        repeat (LAT_M + 1) tick();
        chk("busy_idle_again", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        exp_t e;
        int   t;
        logic [7:0] v;
        RST = 1'b1; req1 = 1'b0;
        bus_in = 8'($urandom); MAR_in = 1'($urandom); MBR_in = 1'($urandom);
        MBR_out = 1'($urandom); req = 1'($urandom); rnw = 1'($urandom);
        prog_we = 1'($urandom); prog_addr = 8'($urandom); prog_data = 8'($urandom);
        repeat (2) tick();
        RST = 1'b0; MAR_in = 1'b0; MBR_in = 1'b0; req = 1'b0; prog_we = 1'b0;
        MBR_out = 1'b1;
        mmar = 8'h00; mmbr = 8'h00;
        @(negedge CLK);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mfc", {31'd0, MFC}, 32'd0);
        chk("rst_mbr", {24'd0, bus_out}, 32'd0);
        chk("rst_busy1", {31'd0, busy1}, 32'd0);

        for (int i = 0; i < 256; i++) prog(8'(i), 8'($urandom));

        // MAR reset value: a read without loading MAR fetches address 0.
        txn(1'b1, 1'b0, 1'b0, 8'h00);

        // Directed read.
        prog(8'h10, 8'hA5);
        load_mar(8'h10);
        txn(1'b1, 1'b0, 1'b0, 8'h00);
        chk("read_mbr", {24'd0, bus_out}, 32'hA5);
        MBR_out = 1'b0; #1;
        chk("bus_out_gated", {24'd0, bus_out}, 32'd0);
        MBR_out = 1'b1; #1;
        chk("bus_out_comb", {24'd0, bus_out}, 32'hA5);

        // Write at top address, then read it back.
        load_mar(8'hFF);
        load_mbr(8'h3C);
        txn(1'b0, 1'b0, 1'b0, 8'h00);
        load_mbr(8'h00);
        txn(1'b1, 1'b0, 1'b0, 8'h00);
        chk("readback_ff", {24'd0, bus_out}, 32'h3C);

        // Inputs asserted during BUSY/DONE must be ignored.
        prog(8'h40, 8'h12);
        prog(8'h41, 8'h34);
        load_mar(8'h40);
        req = 1'b1; rnw = 1'b1;
        e.cyc = edge_n + 1 + LAT_M; e.data = mram[8'h40];
        sbq.push_back(e);
        mmbr = mram[8'h40];
        tick();
        MAR_in = 1'b1; bus_in = 8'h55; prog_we = 1'b1; prog_addr = 8'h41; prog_data = 8'hEE;
        tick();
        MAR_in = 1'b0; prog_we = 1'b0; MBR_in = 1'b1; bus_in = 8'h77;
        tick();
        MBR_in = 1'b0;
        tick();
        req = 1'b0;
        repeat (3) tick();
        chk("ignore_busy_low", {31'd0, busy}, 32'd0);
        chk("ignore_mbr", {24'd0, bus_out}, 32'h12);
        txn(1'b1, 1'b0, 1'b0, 8'h00);
        chk("ignore_mar_kept", {24'd0, bus_out}, 32'h12);
        load_mar(8'h41);
        txn(1'b1, 1'b0, 1'b0, 8'h00);
        chk("ignore_prog_dropped", {24'd0, bus_out}, 32'h34);

        // Reset in the middle of a write aborts it.
        prog(8'h20, 8'h11);
        load_mar(8'h20);
        load_mbr(8'h99);
        req = 1'b1; rnw = 1'b0;
        tick();
        req = 1'b0;
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        mmar = 8'h00; mmbr = 8'h00;
        chk("abort_idle", {31'd0, busy}, 32'd0);
        repeat (4) tick();
        chk("abort_still_idle", {31'd0, busy}, 32'd0);
        chk("abort_mbr_cleared", {24'd0, bus_out}, 32'd0);
        load_mar(8'h20);
        txn(1'b1, 1'b0, 1'b0, 8'h00);
        chk("abort_ram_kept", {24'd0, bus_out}, 32'h11);

        // Held req on the LAT=1 instance: two transactions, pulses 3 edges apart.
        mfc1_q.delete();
        rnw = 1'b1;
        req1 = 1'b1;
        t = edge_n + 1;
        repeat (4) tick();
        req1 = 1'b0;
        repeat (4) tick();
        chk("held_count", mfc1_q.size(), 32'd2);
        if (mfc1_q.size() == 2) begin
            chk("held_first", mfc1_q[0], t + 1);
            chk("held_second", mfc1_q[1], t + 4);
            chk("held_spacing", mfc1_q[1] - mfc1_q[0], 32'd3);
        end
        chk("held_idle", {31'd0, busy1}, 32'd0);

        // Randomized mix of loads, back-door writes and transactions.
        for (int n = 0; n < 80; n++) begin
            v = 8'($urandom);
            case ($urandom_range(0, 4))
                0: prog(8'($urandom), v);
                1: load_mar(v);
                2: load_mbr(v);
                3: txn(1'b1, 1'($urandom), 1'($urandom), v);
                default: txn(1'b0, 1'($urandom), 1'($urandom), v);
            endcase
            MBR_out = 1'($urandom); #1;
            chk("rand_bus_out", {24'd0, bus_out}, MBR_out ? {24'd0, mmbr} : 32'd0);
            MBR_out = 1'b1;
        end

        repeat (4) tick();
        chk("sb_empty", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
